// File: rtl/fifo_pack_if.sv
// fifo_pack_if: write-beat, read and status signals of the packing FIFO.
// The testbench or upstream logic drives through master; fifo_pack is the slave.
interface fifo_pack_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned N_IN   = 16,
    parameter int unsigned DEPTH  = 64
);
    localparam int unsigned SIZE_W = $clog2(N_IN);
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

    logic [WORD_W*N_IN-1:0] data_i;
    logic [SIZE_W-1:0]      size_i;
    logic                   data_we;
    logic [WORD_W-1:0]      data_o;
    logic                   data_rd;
    logic [LVL_W-1:0]       level_o;
    logic [LVL_W-1:0]       credit_o;
    logic                   full;
    logic                   empty;
    logic                   afull;
    logic                   ovf_o;
    logic                   udf_o;

    modport master (
        output data_i, size_i, data_we, data_rd,
        input  data_o, level_o, credit_o, full, empty, afull, ovf_o, udf_o
    );

    modport slave (
        input  data_i, size_i, data_we, data_rd,
        output data_o, level_o, credit_o, full, empty, afull, ovf_o, udf_o
    );
endinterface

// File: rtl/fifo_pack.sv
// fifo_pack: single-clock FIFO accepting 1..N_IN words per write beat and
// returning one word per read. Beats are stored whole or rejected whole.
// Build option: define FIFO_PACK_FWFT_EN for first-word fall-through output;
// otherwise data_o is a register loaded on each accepted read.
module fifo_pack #(
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned N_IN     = 16,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AF_LEVEL = 48
) (
    input  logic       clk,
    input  logic       reset_n,
    fifo_pack_if.slave bus
);
    localparam int unsigned SIZE_W = $clog2(N_IN);
    localparam int unsigned CNT_W  = SIZE_W + 1;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] credit_q, credit_d;
    logic             full_q, empty_q, afull_q, ovf_q, udf_q;
    logic [CNT_W-1:0] n_words;
    logic             wr_acc, rd_acc;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    // Decode beat size, accept/reject decisions and next pointers/level.
    always_comb begin
        n_words  = (bus.size_i == '0) ? CNT_W'(N_IN) : {1'b0, bus.size_i};
        // Space check uses the pre-edge credit: a same-cycle read frees nothing.
        wr_acc   = bus.data_we && (PTR_W'(n_words) <= credit_q);
        rd_acc   = bus.data_rd && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(n_words) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;
        credit_d = PTR_W'(DEPTH) - level_d;
        wr_addr  = wr_ptr_q[ADDR_W-1:0];
        rd_addr  = rd_ptr_q[ADDR_W-1:0];
    end

    // Pointers, registered status and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            credit_q <= PTR_W'(DEPTH);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            credit_q <= credit_d;
            full_q   <= (level_d == PTR_W'(DEPTH));
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= PTR_W'(AF_LEVEL));
            if (bus.data_we && !wr_acc) ovf_q <= 1'b1;
            if (bus.data_rd && empty_q) udf_q <= 1'b1;
        end
    end

    // Storage array, not reset; an accepted beat fills consecutive slots with wrap.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < int'(N_IN); k++) begin
                if (k < int'(n_words)) begin
                    mem[wr_addr + ADDR_W'(k)] <= bus.data_i[k*WORD_W +: WORD_W];
                end
            end
        end
    end

`ifdef FIFO_PACK_FWFT_EN
    // Head word falls through as soon as the FIFO is non-empty.
    always_comb begin
        bus.data_o = empty_q ? '0 : mem[rd_addr];
    end
`else
    logic [WORD_W-1:0] data_q;

    // Output register loaded with the head word on each accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= mem[rd_addr];
        end
    end

    always_comb begin
        bus.data_o = data_q;
    end
`endif

    // Drive status outputs from their registers.
    always_comb begin
        bus.level_o  = level_q;
        bus.credit_o = credit_q;
        bus.full     = full_q;
        bus.empty    = empty_q;
        bus.afull    = afull_q;
        bus.ovf_o    = ovf_q;
        bus.udf_o    = udf_q;
    end
endmodule

// File: tb/tb_fifo_pack.sv
// tb_fifo_pack: directed, table-driven bench for fifo_pack. Works with or
// without FIFO_PACK_FWFT_EN; only the point at which data_o is sampled differs.
module tb_fifo_pack;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned N_IN     = 16;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned AF_LEVEL = 48;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    fifo_pack_if #(.WORD_W(WORD_W), .N_IN(N_IN), .DEPTH(DEPTH)) bus ();

    fifo_pack #(
        .WORD_W  (WORD_W),
        .N_IN    (N_IN),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic        we;
        logic [3:0]  size;
        logic [15:0] base;
        logic        rd;
        int          level;
        int          credit;
        logic        full;
        logic        empty;
        logic        afull;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs[12];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_state(input string name, input int level, input int credit,
                               input logic f, input logic e, input logic af,
                               input logic ov, input logic ud);
        check({name, " level"},  32'(bus.level_o),  32'(level));
        check({name, " credit"}, 32'(bus.credit_o), 32'(credit));
        check({name, " full"},   32'(bus.full),     32'(f));
        check({name, " empty"},  32'(bus.empty),    32'(e));
        check({name, " afull"},  32'(bus.afull),    32'(af));
        check({name, " ovf"},    32'(bus.ovf_o),    32'(ov));
        check({name, " udf"},    32'(bus.udf_o),    32'(ud));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a beat: word k = base + k for valid words, filler elsewhere.
    task automatic load_beat(input logic [3:0] size, input logic [15:0] base);
        int n;
        n = (size == 4'd0) ? 16 : int'(size);
        for (int k = 0; k < int'(N_IN); k++) begin
            bus.data_i[k*WORD_W +: WORD_W] = (k < n) ? base + 16'(k) : 16'hDEAD;
        end
        bus.size_i = size;
    endtask

    task automatic write_beat(input logic [3:0] size, input logic [15:0] base);
        load_beat(size, base);
        bus.data_we = 1'b1;
        step();
        bus.data_we = 1'b0;
    endtask

    task automatic read_word(input logic [15:0] expected);
`ifdef FIFO_PACK_FWFT_EN
        check("rd_data", 32'(bus.data_o), 32'(expected));
        bus.data_rd = 1'b1;
        step();
        bus.data_rd = 1'b0;
`else
        bus.data_rd = 1'b1;
        step();
        bus.data_rd = 1'b0;
        check("rd_data", 32'(bus.data_o), 32'(expected));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          we    size   base      rd    lvl cred full empty afull ovf  udf
        vecs[0]  = '{1'b1, 4'd0, 16'h0100, 1'b0, 16, 48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd0, 16'h0110, 1'b0, 32, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd0, 16'h0120, 1'b0, 48, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd0, 16'h0130, 1'b0, 64,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd0, 16'h0140, 1'b0, 64,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 63,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 62,  2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'd2, 16'h0150, 1'b1, 63,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'd2, 16'h0160, 1'b0, 63,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd1, 16'h0170, 1'b1, 63,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'd1, 16'h0180, 1'b0, 64,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 64,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        bus.data_i  = '0;
        bus.size_i  = '0;
        bus.data_we = 1'b0;
        bus.data_rd = 1'b0;

        // Reset state
        #12;
        check_state("reset", 0, 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset data_o", 32'(bus.data_o), 32'h0);
        reset_n = 1'b1;

        // Three-word beat, then read back in order
        write_beat(4'd3, 16'h0001);
        check_state("w3", 3, 61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        read_word(16'h0001);
        read_word(16'h0002);
        read_word(16'h0003);
        check_state("w3 drained", 0, 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill / overflow / simultaneous write+read table
        foreach (vecs[i]) begin
            load_beat(vecs[i].size, vecs[i].base);
            bus.data_we = vecs[i].we;
            bus.data_rd = vecs[i].rd;
            step();
            bus.data_we = 1'b0;
            bus.data_rd = 1'b0;
            check_state($sformatf("vec%0d", i), vecs[i].level, vecs[i].credit, vecs[i].full,
                        vecs[i].empty, vecs[i].afull, vecs[i].ovf, vecs[i].udf);
        end

        // Drain: rejected beats (0x140, 0x160) must not appear
        for (int i = 16'h0104; i <= 16'h013F; i++) read_word(16'(i));
        read_word(16'h0150);
        read_word(16'h0151);
        read_word(16'h0170);
        read_word(16'h0180);
        check_state("table drained", 0, 64, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Underflow leaves pointers alone
        bus.data_rd = 1'b1;
        step();
        bus.data_rd = 1'b0;
        check_state("udf", 0, 64, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        write_beat(4'd1, 16'h0055);
        check_state("after udf write", 1, 63, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        read_word(16'h0055);

        // Mid-cycle reset clears everything before the next edge
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_state("async reset", 0, 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("async reset data_o", 32'(bus.data_o), 32'h0);
        #2;
        reset_n = 1'b1;
        step();

        // Fill to 60, drain, then an 8-word beat that wraps 63 -> 0
        write_beat(4'd0, 16'h0200);
        write_beat(4'd0, 16'h0210);
        write_beat(4'd0, 16'h0220);
        write_beat(4'd12, 16'h0230);
        check_state("fill60", 60, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) read_word(16'h0200 + 16'(i));
        check_state("drain60", 0, 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        write_beat(4'd8, 16'h00A0);
        check_state("wrap write", 8, 56, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) read_word(16'h00A0 + 16'(i));
        check_state("wrap drained", 0, 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
